// File: rtl/mem_port_arbiter_if.sv
// Shared IF/MEM memory port bundle: requester handshakes plus the
// single-port memory command/response bus.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              ifReq;
   logic [ADDR_W-1:0] ifAddr;
   logic              ifFlush;
   logic              ifValid;
   logic [DATA_W-1:0] ifInstr;
   logic              dReq;
   logic              dWe;
   logic [ADDR_W-1:0] dAddr;
   logic [DATA_W-1:0] dWdata;
   logic              dValid;
   logic [DATA_W-1:0] dRdata;
   logic              stallFetch;
   logic              stallMem;
   logic              mEn;
   logic              mWe;
   logic [ADDR_W-1:0] mAddr;
   logic [DATA_W-1:0] mWdata;
   logic [DATA_W-1:0] mRdata;

   modport slave (
      input  ifReq, ifAddr, ifFlush,
      input  dReq, dWe, dAddr, dWdata,
      input  mRdata,
      output ifValid, ifInstr, dValid, dRdata,
      output stallFetch, stallMem,
      output mEn, mWe, mAddr, mWdata
   );

   modport master (
      output ifReq, ifAddr, ifFlush,
      output dReq, dWe, dAddr, dWdata,
      output mRdata,
      input  ifValid, ifInstr, dValid, dRdata,
      input  stallFetch, stallMem,
      input  mEn, mWe, mAddr, mWdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the shared single-port memory: grants, counts the
// fixed latency, returns one-cycle valid pulses and drives the stall lines.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam int CW = $clog2(MEM_LAT + 1);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;
   localparam logic [CW-1:0] LAT = CW'(MEM_LAT);

   logic [0:0]        state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic              disc_q, disc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              mEn_q, mEn_d;
   logic              mWe_q, mWe_d;
   logic [ADDR_W-1:0] mAddr_q, mAddr_d;
   logic [DATA_W-1:0] mWdata_q, mWdata_d;
   logic              ifValid_q, ifValid_d;
   logic [DATA_W-1:0] ifInstr_q, ifInstr_d;
   logic              dValid_q, dValid_d;
   logic [DATA_W-1:0] dRdata_q, dRdata_d;

   logic busy, done, if_done, d_done;
   logic if_elig, d_elig, issue, win_if;

   always_comb begin
      busy    = state_q == S_BUSY;
      done    = busy && cnt_q == '0;
      if_done = done && owner_q == OWN_IF;
      d_done  = done && owner_q == OWN_D;
      if_elig = bus.ifReq && !ifValid_q && !bus.ifFlush && !if_done;
      d_elig  = bus.dReq && !dValid_q && !d_done;
      issue   = (!busy || done) && (if_elig || d_elig);
      // data by default; fetch takes its turn after a data grant
      win_if  = if_elig && (!d_elig || last_q == OWN_D);
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      disc_d    = disc_q;
      cnt_d     = cnt_q;
      mEn_d     = 1'b0;
      mWe_d     = mWe_q;
      mAddr_d   = mAddr_q;
      mWdata_d  = mWdata_q;
      ifValid_d = 1'b0;
      ifInstr_d = ifInstr_q;
      dValid_d  = 1'b0;
      dRdata_d  = dRdata_q;
      if (busy && owner_q == OWN_IF && bus.ifFlush)
         disc_d = 1'b1;
      if (busy && !done)
         cnt_d = cnt_q - 1'b1;
      if (if_done && !disc_q && !bus.ifFlush) begin
         ifValid_d = 1'b1;
         ifInstr_d = bus.mRdata;
      end
      // mWe_q still holds the owner's direction after mEn drops
      if (d_done) begin
         dValid_d = 1'b1;
         if (!mWe_q)
            dRdata_d = bus.mRdata;
      end
      if (done)
         state_d = S_IDLE;
      if (issue) begin
         state_d = S_BUSY;
         mEn_d   = 1'b1;
         cnt_d   = LAT;
         disc_d  = 1'b0;
         owner_d = win_if ? OWN_IF : OWN_D;
         last_d  = win_if ? OWN_IF : OWN_D;
         if (win_if) begin
            mAddr_d = bus.ifAddr;
            mWe_d   = 1'b0;
         end else begin
            mAddr_d  = bus.dAddr;
            mWe_d    = bus.dWe;
            mWdata_d = bus.dWdata;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         owner_q   <= OWN_IF;
         last_q    <= OWN_IF;
         disc_q    <= 1'b0;
         cnt_q     <= '0;
         mEn_q     <= 1'b0;
         mWe_q     <= 1'b0;
         mAddr_q   <= '0;
         mWdata_q  <= '0;
         ifValid_q <= 1'b0;
         ifInstr_q <= '0;
         dValid_q  <= 1'b0;
         dRdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         disc_q    <= disc_d;
         cnt_q     <= cnt_d;
         mEn_q     <= mEn_d;
         mWe_q     <= mWe_d;
         mAddr_q   <= mAddr_d;
         mWdata_q  <= mWdata_d;
         ifValid_q <= ifValid_d;
         ifInstr_q <= ifInstr_d;
         dValid_q  <= dValid_d;
         dRdata_q  <= dRdata_d;
      end
   end

   assign bus.mEn        = mEn_q;
   assign bus.mWe        = mWe_q;
   assign bus.mAddr      = mAddr_q;
   assign bus.mWdata     = mWdata_q;
   assign bus.ifValid    = ifValid_q;
   assign bus.ifInstr    = ifInstr_q;
   assign bus.dValid     = dValid_q;
   assign bus.dRdata     = dRdata_q;
   assign bus.stallFetch = bus.ifReq & ~ifValid_q;
   assign bus.stallMem   = bus.dReq & ~dValid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, expected
// commands/responses queued up front and checked by a negedge monitor.
module tb_mem_port_arbiter;
   localparam int LAT = 2;

   typedef struct {
      logic [31:0] v;
      int          c;
   } rsp_t;

   typedef struct {
      logic [31:0] a;
      logic        we;
      logic [31:0] wd;
      int          c;
   } cmd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .MEM_LAT(LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   dv_cnt = 0;
   cmd_t cq[$];
   rsp_t ifq[$];
   rsp_t dq[$];
   cmd_t ce;
   rsp_t re;

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   task automatic ex_cmd(input logic [31:0] a, input logic we,
                         input logic [31:0] wd, input int c);
      cq.push_back('{a: a, we: we, wd: wd, c: c});
   endtask

   task automatic ex_if(input logic [31:0] v, input int c);
      ifq.push_back('{v: v, c: c});
   endtask

   task automatic ex_d(input logic [31:0] v, input int c);
      dq.push_back('{v: v, c: c});
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // memory model: read data valid only in cycle (command cycle + LAT)
   int          rd_cyc = -100;
   logic [31:0] rd_addr = '0;
   logic [31:0] mr = 32'h0BAD_0BAD;
   assign bus.mRdata = mr;
   always @(negedge clk) begin
      mr = (cyc == rd_cyc + LAT) ? mem(rd_addr) : 32'h0BAD_0BAD;
      if (bus.mEn && !rst) begin
         rd_cyc  = cyc;
         rd_addr = bus.mAddr;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mEn) begin
            if (cq.size() == 0) chk("unexp_mEn", 64'(bus.mEn), 64'd0);
            else begin
               ce = cq.pop_front();
               chk("cmd_addr", 64'(bus.mAddr), 64'(ce.a));
               chk("cmd_we", 64'(bus.mWe), 64'(ce.we));
               if (ce.we) chk("cmd_wdata", 64'(bus.mWdata), 64'(ce.wd));
               chk("cmd_cyc", 64'(cyc), 64'(ce.c));
            end
         end
         if (bus.ifValid) begin
            if (ifq.size() == 0) chk("unexp_ifValid", 64'(bus.ifValid), 64'd0);
            else begin
               re = ifq.pop_front();
               chk("ifInstr", 64'(bus.ifInstr), 64'(re.v));
               chk("ifValid_cyc", 64'(cyc), 64'(re.c));
            end
         end
         if (bus.dValid) begin
            dv_cnt++;
            if (dq.size() == 0) chk("unexp_dValid", 64'(bus.dValid), 64'd0);
            else begin
               re = dq.pop_front();
               chk("dRdata", 64'(bus.dRdata), 64'(re.v));
               chk("dValid_cyc", 64'(cyc), 64'(re.c));
            end
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_fetch(input logic [31:0] a);
      bit got = 1'b0;
      bus.ifAddr = a;
      bus.ifReq  = 1'b1;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (bus.ifValid) begin
            got = 1'b1;
            chk("stallFetch_lo", 64'(bus.stallFetch), 64'd0);
         end else chk("stallFetch_hi", 64'(bus.stallFetch), 64'd1);
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL if_timeout addr=%h got=none want=ifValid", a);
      end
      nxt();
      bus.ifReq = 1'b0;
   endtask

   task automatic do_data(input logic we, input logic [31:0] a,
                          input logic [31:0] wd);
      bit got = 1'b0;
      bus.dWe    = we;
      bus.dAddr  = a;
      bus.dWdata = wd;
      bus.dReq   = 1'b1;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (bus.dValid) begin
            got = 1'b1;
            chk("stallMem_lo", 64'(bus.stallMem), 64'd0);
         end else chk("stallMem_hi", 64'(bus.stallMem), 64'd1);
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL d_timeout addr=%h got=none want=dValid", a);
      end
      nxt();
      bus.dReq = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

   int b;
   int dv0;

   initial begin
      bus.ifReq   = 1'b0;
      bus.ifAddr  = '0;
      bus.ifFlush = 1'b0;
      bus.dReq    = 1'b0;
      bus.dWe     = 1'b0;
      bus.dAddr   = '0;
      bus.dWdata  = '0;
      nxt();
      nxt();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mEn", 64'(bus.mEn), 64'd0);
      chk("rst_mbus", 64'({bus.mWe, bus.mAddr}), 64'd0);
      chk("rst_mWdata", 64'(bus.mWdata), 64'd0);
      chk("rst_valids", 64'({bus.ifValid, bus.dValid}), 64'd0);
      chk("rst_ifInstr", 64'(bus.ifInstr), 64'd0);
      chk("rst_dRdata", 64'(bus.dRdata), 64'd0);
      chk("rst_stalls", 64'({bus.stallFetch, bus.stallMem}), 64'd0);
      nxt();

      // single fetch
      b = cyc;
      ex_cmd(32'h10, 1'b0, 32'h0, b + 1);
      ex_if(32'hDEAD_BEEF, b + 4);
      do_fetch(32'h10);

      // simultaneous fetch and load: data first
      b = cyc;
      ex_cmd(32'h100, 1'b0, 32'h0, b + 1);
      ex_d(mem(32'h100), b + 4);
      ex_cmd(32'h20, 1'b0, 32'h0, b + 4);
      ex_if(mem(32'h20), b + 7);
      fork
         do_fetch(32'h20);
         do_data(1'b0, 32'h100, 32'h0);
      join

      // store with fetch pending, then an immediate new load
      b = cyc;
      ex_cmd(32'h200, 1'b1, 32'h1234_5678, b + 1);
      ex_d(mem(32'h100), b + 4);
      ex_cmd(32'h30, 1'b0, 32'h0, b + 4);
      ex_if(mem(32'h30), b + 7);
      ex_cmd(32'h300, 1'b0, 32'h0, b + 7);
      ex_d(mem(32'h300), b + 10);
      fork
         do_fetch(32'h30);
         begin
            do_data(1'b1, 32'h200, 32'h1234_5678);
            do_data(1'b0, 32'h300, 32'h0);
         end
      join

      // last grant was data: fetch wins the tie
      b = cyc;
      ex_cmd(32'h40, 1'b0, 32'h0, b + 1);
      ex_if(mem(32'h40), b + 4);
      ex_cmd(32'h400, 1'b1, 32'hCAFE_F00D, b + 4);
      ex_d(mem(32'h300), b + 7);
      fork
         do_fetch(32'h40);
         do_data(1'b1, 32'h400, 32'hCAFE_F00D);
      join

      // flush of an in-flight fetch
      b = cyc;
      ex_cmd(32'h50, 1'b0, 32'h0, b + 1);
      bus.ifAddr = 32'h50;
      bus.ifReq  = 1'b1;
      nxt();
      nxt();
      bus.ifFlush = 1'b1;
      nxt();
      bus.ifFlush = 1'b0;
      bus.ifReq   = 1'b0;
      nxt();
      ex_cmd(32'h60, 1'b0, 32'h0, b + 5);
      ex_if(mem(32'h60), b + 8);
      fork
         do_fetch(32'h60);
         begin
            @(negedge clk);
            chk("flush_noValid", 64'(bus.ifValid), 64'd0);
            chk("flush_instr_kept", 64'(bus.ifInstr), 64'(mem(32'h40)));
         end
      join

      // flush in idle blocks the fetch issue for that cycle
      b = cyc;
      ex_cmd(32'h70, 1'b0, 32'h0, b + 2);
      ex_if(mem(32'h70), b + 5);
      bus.ifAddr  = 32'h70;
      bus.ifReq   = 1'b1;
      bus.ifFlush = 1'b1;
      nxt();
      bus.ifFlush = 1'b0;
      fork
         do_fetch(32'h70);
         begin
            @(negedge clk);
            chk("flush_idle_noEn", 64'(bus.mEn), 64'd0);
         end
      join

      // async reset in the middle of a load
      b = cyc;
      ex_cmd(32'h500, 1'b0, 32'h0, b + 1);
      bus.dWe   = 1'b0;
      bus.dAddr = 32'h500;
      bus.dReq  = 1'b1;
      nxt();
      nxt();
      dv0 = dv_cnt;
      #1 rst = 1'b1;
      bus.dReq = 1'b0;
      #1;
      chk("arst_mEn", 64'(bus.mEn), 64'd0);
      chk("arst_mbus", 64'({bus.mWe, bus.mAddr}), 64'd0);
      chk("arst_mWdata", 64'(bus.mWdata), 64'd0);
      chk("arst_valids", 64'({bus.ifValid, bus.dValid}), 64'd0);
      chk("arst_ifInstr", 64'(bus.ifInstr), 64'd0);
      chk("arst_dRdata", 64'(bus.dRdata), 64'd0);
      #1 rst = 1'b0;
      repeat (5) nxt();
      chk("arst_no_dValid", 64'(dv_cnt), 64'(dv0));

      b = cyc;
      ex_cmd(32'h600, 1'b0, 32'h0, b + 1);
      ex_d(mem(32'h600), b + 4);
      do_data(1'b0, 32'h600, 32'h0);

      repeat (3) nxt();
      chk("cmd_q_empty", 64'(cq.size()), 64'd0);
      chk("if_q_empty", 64'(ifq.size()), 64'd0);
      chk("d_q_empty", 64'(dq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
